// File: rtl/mac_vec.sv
// mac_vec: multi-lane dot-product MAC with per-frame accumulation.
//   Each accepted beat carries LANES operand pairs. Their products are summed and
//   accumulated over a frame of cfg_len beats. One result per frame is emitted on
//   a valid/ready output.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   cfg_signed, cfg_len   operand signedness and frame length, sampled on the SOF beat
//   in_valid/in_ready     input beat handshake; in_sof marks the first beat of a frame
//   in_a, in_b            packed lane operands, lane k = [k*WIDTH +: WIDTH]
//   out_valid/out_ready   result handshake; out_c holds the dot product
//   err                   one-cycle pulse when a frame is aborted by an early SOF
module mac_vec #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned LANES     = 4,
  parameter int unsigned N_MAX     = 64,
  parameter int unsigned MUL_PIPE  = 2,
  parameter int unsigned LEN_W     = $clog2(N_MAX + 1),
  parameter int unsigned ACC_WIDTH = 2 * WIDTH + $clog2(LANES) + $clog2(N_MAX)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_signed,
  input  logic [LEN_W-1:0]       cfg_len,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_sof,
  input  logic [LANES*WIDTH-1:0] in_a,
  input  logic [LANES*WIDTH-1:0] in_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ACC_WIDTH-1:0]   out_c,
  output logic                   err
);

  // Products are kept one bit wider than 2*WIDTH so that signed and unsigned
  // results share one sign-extending datapath.
  localparam int unsigned PW = 2 * WIDTH + 1;
  localparam int unsigned FW = 2 * WIDTH + 2;

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_DRAIN, S_OUT} state_e;

  state_e                 state_q;
  logic                   sgn_q;
  logic [LEN_W-1:0]       len_q;
  logic [LEN_W-1:0]       cnt_q;
  logic                   out_valid_q;
  logic [ACC_WIDTH-1:0]   out_c_q;
  logic                   err_q;

  logic [LEN_W-1:0]       len_cfg;
  logic [LEN_W-1:0]       cnt_inc;
  logic                   accept;
  logic                   beat_vld;
  logic                   beat_sgn;
  logic                   beat_last;

  logic signed [WIDTH:0]  a_ext;
  logic signed [WIDTH:0]  b_ext;
  logic signed [FW-1:0]   full;
  logic signed [PW-1:0]   prod_d [LANES];
  logic signed [PW-1:0]   prod_q [MUL_PIPE][LANES];
  logic [MUL_PIPE-1:0]    pv_q;
  logic [MUL_PIPE-1:0]    ps_q;
  logic [MUL_PIPE-1:0]    pl_q;

  logic signed [ACC_WIDTH-1:0] sum_d;
  logic signed [ACC_WIDTH-1:0] tree_q;
  logic                        tree_vld_q;
  logic                        tree_sof_q;
  logic                        tree_last_q;
  logic signed [ACC_WIDTH-1:0] acc_q;
  logic                        acc_last_q;

  // Frame length as seen on the SOF beat: 0 means 1, oversize clamps to N_MAX.
  always_comb begin
    if (cfg_len == '0) begin
      len_cfg = LEN_W'(1);
    end else if (cfg_len > LEN_W'(N_MAX)) begin
      len_cfg = LEN_W'(N_MAX);
    end else begin
      len_cfg = cfg_len;
    end
  end

  assign in_ready = rst_n && (state_q == S_IDLE || state_q == S_ACC);
  assign accept   = in_valid && in_ready;
  // Non-SOF beats arriving in IDLE are accepted but not entered into the pipe.
  assign beat_vld = accept && (in_sof || state_q == S_ACC);
  // The SOF beat uses the config presented with it, later beats the latched copy.
  assign beat_sgn  = in_sof ? cfg_signed : sgn_q;
  assign cnt_inc   = cnt_q + LEN_W'(1);
  assign beat_last = in_sof ? (len_cfg == LEN_W'(1)) : (cnt_inc == len_q);

  always_comb begin
    a_ext = '0;
    b_ext = '0;
    full  = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      a_ext     = {beat_sgn & in_a[k*WIDTH+WIDTH-1], in_a[k*WIDTH +: WIDTH]};
      b_ext     = {beat_sgn & in_b[k*WIDTH+WIDTH-1], in_b[k*WIDTH +: WIDTH]};
      full      = FW'(a_ext) * FW'(b_ext);
      prod_d[k] = full[PW-1:0];
    end
  end

  // Multiplier pipeline tags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pv_q <= '0;
      ps_q <= '0;
      pl_q <= '0;
    end else begin
      pv_q[0] <= beat_vld;
      ps_q[0] <= in_sof;
      pl_q[0] <= beat_last;
      for (int unsigned i = 1; i < MUL_PIPE; i++) begin
        pv_q[i] <= pv_q[i-1];
        ps_q[i] <= ps_q[i-1];
        pl_q[i] <= pl_q[i-1];
      end
    end
  end

  // Multiplier pipeline data.
  always_ff @(posedge clk) begin
    prod_q[0] <= prod_d;
    for (int unsigned i = 1; i < MUL_PIPE; i++) begin
      prod_q[i] <= prod_q[i-1];
    end
  end

  always_comb begin
    sum_d = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      sum_d = sum_d + ACC_WIDTH'(prod_q[MUL_PIPE-1][k]);
    end
  end

  // Adder-tree and accumulator stages.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tree_vld_q  <= 1'b0;
      tree_sof_q  <= 1'b0;
      tree_last_q <= 1'b0;
      acc_last_q  <= 1'b0;
    end else begin
      tree_vld_q  <= pv_q[MUL_PIPE-1];
      tree_sof_q  <= ps_q[MUL_PIPE-1];
      tree_last_q <= pl_q[MUL_PIPE-1];
      acc_last_q  <= tree_vld_q && tree_last_q;
    end
  end

  // An SOF-tagged beat reloads the sum, which also discards an aborted frame.
  always_ff @(posedge clk) begin
    tree_q <= sum_d;
    if (tree_vld_q) begin
      acc_q <= tree_sof_q ? tree_q : acc_q + tree_q;
    end
  end

  // Frame control.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      sgn_q       <= 1'b0;
      len_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_c_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      err_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (accept && in_sof) begin
            sgn_q   <= cfg_signed;
            len_q   <= len_cfg;
            cnt_q   <= LEN_W'(1);
            state_q <= (len_cfg == LEN_W'(1)) ? S_DRAIN : S_ACC;
          end
        end
        S_ACC: begin
          if (accept) begin
            if (in_sof) begin
              err_q   <= 1'b1;
              sgn_q   <= cfg_signed;
              len_q   <= len_cfg;
              cnt_q   <= LEN_W'(1);
              state_q <= (len_cfg == LEN_W'(1)) ? S_DRAIN : S_ACC;
            end else begin
              cnt_q <= cnt_inc;
              if (cnt_inc == len_q) begin
                state_q <= S_DRAIN;
              end
            end
          end
        end
        S_DRAIN: begin
          if (acc_last_q) begin
            state_q     <= S_OUT;
            out_valid_q <= 1'b1;
            out_c_q     <= acc_q;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_c     = out_c_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mac_vec.sv
// Testbench for mac_vec: table of whole-frame vectors plus hand-written sequences
// for backpressure, early-SOF abort and mid-frame reset. Results are checked by a
// scoreboard queue filled when a frame's last beat is driven.
module tb_mac_vec;

  localparam int unsigned WIDTH     = 16;
  localparam int unsigned LANES     = 4;
  localparam int unsigned N_MAX     = 64;
  localparam int unsigned MUL_PIPE  = 2;
  localparam int unsigned LEN_W     = 7;
  localparam int unsigned ACC_WIDTH = 40;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   cfg_signed = 1'b0;
  logic [LEN_W-1:0]       cfg_len = '0;
  logic                   in_valid = 1'b0;
  logic                   in_ready;
  logic                   in_sof = 1'b0;
  logic [LANES*WIDTH-1:0] in_a = '0;
  logic [LANES*WIDTH-1:0] in_b = '0;
  logic                   out_valid;
  logic                   out_ready = 1'b1;
  logic [ACC_WIDTH-1:0]   out_c;
  logic                   err;

  always #5 clk = ~clk;

  mac_vec #(
    .WIDTH    (WIDTH),
    .LANES    (LANES),
    .N_MAX    (N_MAX),
    .MUL_PIPE (MUL_PIPE),
    .LEN_W    (LEN_W),
    .ACC_WIDTH(ACC_WIDTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_signed(cfg_signed),
    .cfg_len   (cfg_len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sof    (in_sof),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_c     (out_c),
    .err       (err)
  );

  typedef struct {
    bit          sgn;
    logic [6:0]  len;
    int unsigned beats;
    logic [63:0] a;
    logic [63:0] b;
    logic [39:0] exp;
  } vec_t;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;
  logic [39:0] sb_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference dot product of one beat, reduced to the 40-bit result width.
  function automatic logic [39:0] dot(input bit sgn, input logic [63:0] a, input logic [63:0] b);
    longint s = 0;
    for (int k = 0; k < 4; k++) begin
      logic [15:0] ua = a[k*16 +: 16];
      logic [15:0] ub = b[k*16 +: 16];
      longint x = sgn ? longint'($signed(ua)) : longint'(ua);
      longint y = sgn ? longint'($signed(ub)) : longint'(ub);
      s += x * y;
    end
    return s[39:0];
  endfunction

  // Scoreboard: compare on the cycle before each output handshake edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_result: got %0h, expected no result", out_c);
      end else begin
        check("result", out_c, sb_q.pop_front());
      end
    end
  end

  // Non-SOF beats carry the opposite signedness and a random length so that
  // any use of unlatched config shows up in the result.
  task automatic drive_beat(input bit sof, input bit sgn, input logic [6:0] len,
                            input logic [63:0] a, input logic [63:0] b);
    int unsigned w = 0;
    in_valid   = 1'b1;
    in_sof     = sof;
    in_a       = a;
    in_b       = b;
    cfg_signed = sof ? sgn : ~sgn;
    cfg_len    = sof ? len : 7'($urandom_range(0, 127));
    while (!in_ready && w < 500) begin
      @(posedge clk); #1;
      w++;
    end
    if (!in_ready) begin
      n_total++;
      $display("FAIL in_ready_timeout: in_ready=0 after %0d cycles, expected 1", w);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic idle_cycles(input int unsigned n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_frame(input vec_t v, input int unsigned gap_max);
    for (int unsigned j = 0; j < v.beats; j++) begin
      drive_beat(j == 0, v.sgn, v.len, v.a, v.b);
      if (j == v.beats - 1) sb_q.push_back(v.exp);
      else idle_cycles($urandom_range(0, gap_max));
    end
  endtask

  task automatic drain(input string name);
    int unsigned w = 0;
    while (sb_q.size() != 0 && w < 400) begin
      @(posedge clk); #1;
      w++;
    end
    check(name, 64'(sb_q.size()), 64'd0);
    idle_cycles(2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[8];
    vec_t        v;
    int unsigned w;
    bit          sgn;
    int unsigned len;
    logic [63:0] ra, rb;
    logic [39:0] e;

    tbl[0] = '{1'b0, 7'd1,   1,  64'h0004_0003_0002_0001, 64'h0008_0007_0006_0005, 40'd70};
    tbl[1] = '{1'b1, 7'd3,   3,  64'hFFFF_FFFF_FFFF_FFFF, 64'h7FFF_7FFF_7FFF_7FFF, -40'sd393204};
    tbl[2] = '{1'b0, 7'd64,  64, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 40'hFF_FE00_0100};
    tbl[3] = '{1'b1, 7'd2,   2,  64'h8000_8000_8000_8000, 64'h8000_8000_8000_8000, 40'h02_0000_0000};
    tbl[4] = '{1'b0, 7'd0,   1,  64'h0003_0003_0003_0003, 64'h0003_0003_0003_0003, 40'd36};
    tbl[5] = '{1'b0, 7'd100, 64, 64'h0001_0001_0001_0001, 64'h0002_0002_0002_0002, 40'd512};
    tbl[6] = '{1'b1, 7'd1,   1,  64'hFFFF_FFFF_FFFF_FFFF, 64'h0002_0002_0002_0002, -40'sd8};
    tbl[7] = '{1'b0, 7'd1,   1,  64'hFFFF_FFFF_FFFF_FFFF, 64'h0002_0002_0002_0002, 40'd524280};

    // Reset state.
    rst_n = 1'b0;
    idle_cycles(3);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_c", 64'(out_c), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    rst_n = 1'b1;
    idle_cycles(1);
    check("idle_in_ready", 64'(in_ready), 64'd1);

    // A non-SOF beat in IDLE is dropped; the block stays ready.
    drive_beat(1'b0, 1'b0, 7'd1, '1, '1);
    check("stray_in_ready", 64'(in_ready), 64'd1);
    idle_cycles(6);
    check("stray_no_output", 64'(out_valid), 64'd0);

    // Table of whole frames, back to back.
    for (int unsigned i = 0; i < 8; i++) begin
      send_frame(tbl[i], 0);
      if (i == 0) begin
        check("lat_drain_in_ready", 64'(in_ready), 64'd0);
        idle_cycles(3);
        check("lat_edge3_out_valid", 64'(out_valid), 64'd0);
        idle_cycles(1);
        check("lat_edge4_out_valid", 64'(out_valid), 64'd1);
      end
      drain("table_drain");
    end

    // Output backpressure: result held stable, input blocked.
    out_ready = 1'b0;
    send_frame(tbl[0], 0);
    w = 0;
    while (!out_valid && w < 20) begin
      idle_cycles(1);
      w++;
    end
    for (int unsigned c = 0; c < 10; c++) begin
      check("hold_out_valid", 64'(out_valid), 64'd1);
      check("hold_out_c", 64'(out_c), 64'(tbl[0].exp));
      check("hold_in_ready", 64'(in_ready), 64'd0);
      idle_cycles(1);
    end
    out_ready = 1'b1;
    idle_cycles(1);
    check("release_out_valid", 64'(out_valid), 64'd0);
    check("release_in_ready", 64'(in_ready), 64'd1);
    drain("hold_drain");

    // Early SOF at beat 3 of a len=4 frame aborts it.
    drive_beat(1'b1, 1'b0, 7'd4, 64'h0064_0064_0064_0064, 64'h0064_0064_0064_0064);
    check("normal_sof_err", 64'(err), 64'd0);
    drive_beat(1'b0, 1'b0, 7'd4, 64'h0064_0064_0064_0064, 64'h0064_0064_0064_0064);
    drive_beat(1'b1, 1'b0, 7'd2, tbl[0].a, tbl[0].b);
    check("abort_err_pulse", 64'(err), 64'd1);
    idle_cycles(1);
    check("abort_err_clear", 64'(err), 64'd0);
    drive_beat(1'b0, 1'b0, 7'd2, tbl[0].a, tbl[0].b);
    sb_q.push_back(40'd140);
    check("abort_new_drain", 64'(in_ready), 64'd0);
    drain("abort_drain");

    // Reset in the middle of a frame discards it.
    for (int unsigned j = 0; j < 3; j++) begin
      drive_beat(j == 0, 1'b0, 7'd8, 64'h0005_0005_0005_0005, 64'h0005_0005_0005_0005);
    end
    rst_n = 1'b0;
    idle_cycles(1);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_err", 64'(err), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd0);
    idle_cycles(1);
    rst_n = 1'b1;
    idle_cycles(1);
    check("postrst_in_ready", 64'(in_ready), 64'd1);

    // Random frames with in_valid gaps against the reference model.
    for (int unsigned r = 0; r < 4; r++) begin
      sgn = ($urandom_range(0, 1) == 1);
      len = $urandom_range(5, 20);
      e   = '0;
      for (int unsigned j = 0; j < len; j++) begin
        ra = {$urandom, $urandom};
        rb = {$urandom, $urandom};
        e  = e + dot(sgn, ra, rb);
        drive_beat(j == 0, sgn, 7'(len), ra, rb);
        if (j == len - 1) sb_q.push_back(e);
        else idle_cycles($urandom_range(0, 3));
      end
    end
    drain("random_drain");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
